// File: rtl/morse_rx_frontend_pkg.sv
// Shared types and constants for the Morse receiver front end.
// Symbol encoding: dot = 0, dash = 1; symbols shift in at the LSB, so the
// first symbol of a letter sits in the MSB of the used bits.
package morse_rx_frontend_pkg;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [7:0]  ASCII_QMARK = 8'h3F;

  // Fixed LUT key widths; the top zero-extends its symbol registers into these
  localparam int unsigned LUT_LEN_W   = 4;
  localparam int unsigned LUT_BITS_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_GAP,
    S_WORD_WAIT
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] ascii;
  } lut_res_t;

endpackage

// File: rtl/morse_rx_frontend_if.sv
// Letter output stream plus status pulses of the Morse receiver.
//  letter_data  : ASCII at FIFO head
//  letter_valid : FIFO non-empty
//  letter_ready : consumer accepts letter_data when valid & ready at posedge
//  drop         : 1-cycle pulse, letter discarded because FIFO full
//  sym_error    : 1-cycle pulse, unknown pattern or too many symbols
//  busy         : decoder FSM not idle
interface morse_rx_frontend_if;

  logic [7:0] letter_data;
  logic       letter_valid;
  logic       letter_ready;
  logic       drop;
  logic       sym_error;
  logic       busy;

  modport master (
    output letter_data, letter_valid, drop, sym_error, busy,
    input  letter_ready
  );

  modport slave (
    input  letter_data, letter_valid, drop, sym_error, busy,
    output letter_ready
  );

endinterface

// File: rtl/morse_rx_frontend_lut.sv
// Combinational Morse pattern decoder: (sym_len, sym_bits) -> {hit, ascii}.
//  sym_len  : number of received symbols
//  sym_bits : symbols, first in MSB of used bits, unused upper bits zero
//  res_c    : hit = pattern is a letter A-Z or digit 0-9
module morse_rx_frontend_lut
  import morse_rx_frontend_pkg::*;
(
  input  logic [LUT_LEN_W-1:0]  sym_len,
  input  logic [LUT_BITS_W-1:0] sym_bits,
  output lut_res_t              res_c
);

  logic [7:0] ascii_c;

  // Unused upper bits are always zero, so the full key is matched exactly
  always_comb begin
    ascii_c = 8'h00;
    case ({sym_len, sym_bits})
      {4'd1, 8'b0}:     ascii_c = "E";
      {4'd1, 8'b1}:     ascii_c = "T";
      {4'd2, 8'b00}:    ascii_c = "I";
      {4'd2, 8'b01}:    ascii_c = "A";
      {4'd2, 8'b10}:    ascii_c = "N";
      {4'd2, 8'b11}:    ascii_c = "M";
      {4'd3, 8'b000}:   ascii_c = "S";
      {4'd3, 8'b001}:   ascii_c = "U";
      {4'd3, 8'b010}:   ascii_c = "R";
      {4'd3, 8'b011}:   ascii_c = "W";
      {4'd3, 8'b100}:   ascii_c = "D";
      {4'd3, 8'b101}:   ascii_c = "K";
      {4'd3, 8'b110}:   ascii_c = "G";
      {4'd3, 8'b111}:   ascii_c = "O";
      {4'd4, 8'b0000}:  ascii_c = "H";
      {4'd4, 8'b0001}:  ascii_c = "V";
      {4'd4, 8'b0010}:  ascii_c = "F";
      {4'd4, 8'b0100}:  ascii_c = "L";
      {4'd4, 8'b0110}:  ascii_c = "P";
      {4'd4, 8'b0111}:  ascii_c = "J";
      {4'd4, 8'b1000}:  ascii_c = "B";
      {4'd4, 8'b1001}:  ascii_c = "X";
      {4'd4, 8'b1010}:  ascii_c = "C";
      {4'd4, 8'b1011}:  ascii_c = "Y";
      {4'd4, 8'b1100}:  ascii_c = "Z";
      {4'd4, 8'b1101}:  ascii_c = "Q";
      {4'd5, 8'b11111}: ascii_c = "0";
      {4'd5, 8'b01111}: ascii_c = "1";
      {4'd5, 8'b00111}: ascii_c = "2";
      {4'd5, 8'b00011}: ascii_c = "3";
      {4'd5, 8'b00001}: ascii_c = "4";
      {4'd5, 8'b00000}: ascii_c = "5";
      {4'd5, 8'b10000}: ascii_c = "6";
      {4'd5, 8'b11000}: ascii_c = "7";
      {4'd5, 8'b11100}: ascii_c = "8";
      {4'd5, 8'b11110}: ascii_c = "9";
      default:          ascii_c = 8'h00;
    endcase
  end

  assign res_c.hit   = (ascii_c != 8'h00);
  assign res_c.ascii = ascii_c;

endmodule

// File: rtl/morse_rx_frontend.sv
// Morse receiver front end: synchronises key_in, times marks/gaps in
// prescaled ticks, classifies dot/dash, decodes letters, inserts word spaces
// and buffers ASCII in a small FIFO.
//  clk, rst_n : clock, asynchronous active-low reset
//  key_in     : raw asynchronous key (1 = key down)
//  rx         : letter stream and status pulses (see morse_rx_frontend_if)
module morse_rx_frontend
  import morse_rx_frontend_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned CLK_PER_TICK     = 1000,
  parameter int unsigned DOT_MAX_TICKS    = 3,
  parameter int unsigned LETTER_GAP_TICKS = 3,
  parameter int unsigned WORD_GAP_TICKS   = 7,
  parameter int unsigned MAX_SYMS         = 6,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_in,
  morse_rx_frontend_if.master rx
);

  localparam int unsigned PRESC_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int unsigned LEN_W   = $clog2(MAX_SYMS + 2);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   key_prev_q, key_prev_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]       dur_q, dur_d;
  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       sym_len_q, sym_len_d;
  logic [MAX_SYMS-1:0]    sym_bits_q, sym_bits_d;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [7:0]             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   valid_q, valid_d, busy_q, busy_d;
  logic                   drop_q, drop_d, serr_q, serr_d;

  logic       key_s, rise_c, fall_c, edge_c, tick_c, dash_c, letter_ok_c;
  logic       push_c, serr_c, pop_c, full_c, wr_en_c, drop_c;
  logic [7:0] push_data_c;
  lut_res_t   lut_res_c;

  assign key_s  = sync_q[SYNC_STAGES-1];
  assign rise_c = key_s & ~key_prev_q;
  assign fall_c = ~key_s & key_prev_q;
  assign edge_c = rise_c | fall_c;

  // Synchroniser shift and edge-detect history
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], key_in};
    key_prev_d = key_s;
  end

  // Prescaler and duration counter both restart on every key edge; the edge
  // cycle never ticks, so an N-tick interval spans N*CLK_PER_TICK+1 cycles
  always_comb begin
    tick_c  = 1'b0;
    presc_d = presc_q + 1'b1;
    if (edge_c) begin
      presc_d = '0;
    end else if (presc_q == PRESC_W'(CLK_PER_TICK - 1)) begin
      tick_c  = 1'b1;
      presc_d = '0;
    end
    dur_d = dur_q;
    if (edge_c) begin
      dur_d = '0;
    end else if (tick_c && (dur_q != '1)) begin
      dur_d = dur_q + 1'b1;
    end
  end

  morse_rx_frontend_lut u_lut (
    .sym_len  (LUT_LEN_W'(sym_len_q)),
    .sym_bits (LUT_BITS_W'(sym_bits_q)),
    .res_c    (lut_res_c)
  );

  assign dash_c      = (dur_q > CNT_W'(DOT_MAX_TICKS));
  assign letter_ok_c = lut_res_c.hit && (sym_len_q <= LEN_W'(MAX_SYMS));

  // Decoder FSM next-state, symbol assembly and FIFO push request
  always_comb begin
    state_d     = state_q;
    sym_len_d   = sym_len_q;
    sym_bits_d  = sym_bits_q;
    push_c      = 1'b0;
    push_data_c = ASCII_SPACE;
    serr_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise_c) state_d = S_MARK;
      end
      S_MARK: begin
        if (fall_c) begin
          if (dur_q == '0) begin
            // Sub-tick glitch: resume where we were before the mark
            state_d = (sym_len_q == '0) ? S_IDLE : S_GAP;
          end else begin
            state_d = S_GAP;
            if (sym_len_q < LEN_W'(MAX_SYMS)) sym_bits_d = {sym_bits_q[MAX_SYMS-2:0], dash_c};
            if (sym_len_q != '1) sym_len_d = sym_len_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (rise_c) begin
          state_d = S_MARK;
        end else if (tick_c && (dur_q == CNT_W'(LETTER_GAP_TICKS - 1))) begin
          state_d    = S_WORD_WAIT;
          push_c     = 1'b1;
          sym_len_d  = '0;
          sym_bits_d = '0;
          if (letter_ok_c) begin
            push_data_c = lut_res_c.ascii;
          end else begin
            push_data_c = ASCII_QMARK;
            serr_c      = 1'b1;
          end
        end
      end
      S_WORD_WAIT: begin
        if (rise_c) begin
          state_d = S_MARK;
        end else if (tick_c && (dur_q == CNT_W'(WORD_GAP_TICKS - 1))) begin
          state_d = S_IDLE;
          push_c  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output FIFO: a push into a full FIFO survives only if a pop frees a slot
  assign pop_c   = valid_q & rx.letter_ready;
  assign full_c  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign wr_en_c = push_c & (~full_c | pop_c);
  assign drop_c  = push_c & full_c & ~pop_c;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en_c) begin
      mem_d[wr_ptr_q] = push_data_c;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en_c, pop_c})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    valid_d = (occ_d != '0);
    busy_d  = (state_d != S_IDLE);
    drop_d  = drop_c;
    serr_d  = serr_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      key_prev_q <= 1'b0;
      presc_q    <= '0;
      dur_q      <= '0;
      state_q    <= S_IDLE;
      sym_len_q  <= '0;
      sym_bits_q <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      key_prev_q <= key_prev_d;
      presc_q    <= presc_d;
      dur_q      <= dur_d;
      state_q    <= state_d;
      sym_len_q  <= sym_len_d;
      sym_bits_q <= sym_bits_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      serr_q     <= serr_d;
    end
  end

  assign rx.letter_data  = mem_q[rd_ptr_q];
  assign rx.letter_valid = valid_q;
  assign rx.drop         = drop_q;
  assign rx.sym_error    = serr_q;
  assign rx.busy         = busy_q;

endmodule
